// File: rtl/seg_pkg.sv
// Shared types and defaults for the multiplexed 4-digit hex display scanner.
package seg_pkg;
    localparam int SEG_SCAN_DIV = 100000;

    typedef logic [1:0]  digit_idx_t;
    typedef logic [3:0]  nibble_t;
    typedef logic [15:0] hex4_t;
endpackage

// File: rtl/seg_prescaler.sv
// Free-running divider: counts 0..SCAN_DIV-1 and flags the last count as tick.
module seg_prescaler #(
    parameter int SCAN_DIV = 100000
) (
    input  logic clk,
    input  logic rst,
    output logic o_tick
);
    localparam int CW = (SCAN_DIV > 2) ? $clog2(SCAN_DIV) : 1;
    localparam logic [CW-1:0] LAST = CW'(SCAN_DIV - 1);

    logic [CW-1:0] r_cnt;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_cnt <= '0;
        end else if (r_cnt == LAST) begin
            r_cnt <= '0;
        end else begin
            r_cnt <= r_cnt + 1'b1;
        end
    end

    assign o_tick = (r_cnt == LAST);
endmodule

// File: rtl/seg_scan.sv
// Tear-free 4-digit hex scanner with shadow/display double buffering.
// Optional leading-zero blanking is compiled in when SEG_LZB_EN is defined.
module seg_scan
    import seg_pkg::*;
#(
    parameter int SCAN_DIV = SEG_SCAN_DIV
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        load,
    input  logic [15:0] data,
    output logic [1:0]  sel,
    output logic [3:0]  hex,
    output logic        blank,
    output logic        pending,
    output logic        frame_tick
);
    logic       w_tick;
    logic       w_commit;
    digit_idx_t r_sel;
    hex4_t      r_shadow;
    hex4_t      r_display;
    logic       r_pending;
    logic       r_frame_tick;

    seg_prescaler #(.SCAN_DIV(SCAN_DIV)) u_prescaler (
        .clk    (clk),
        .rst    (rst),
        .o_tick (w_tick)
    );

    // The tick that wraps digit 3 back to 0 is the only point display may change.
    assign w_commit = w_tick && (r_sel == 2'd3);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_sel        <= '0;
            r_shadow     <= '0;
            r_display    <= '0;
            r_pending    <= 1'b0;
            r_frame_tick <= 1'b0;
        end else begin
            r_frame_tick <= w_commit;
            if (w_tick) begin
                r_sel <= r_sel + 1'b1;
            end
            if (load && w_commit) begin
                r_shadow  <= data;
                r_display <= data;
                r_pending <= 1'b0;
            end else if (load) begin
                r_shadow  <= data;
                r_pending <= 1'b1;
            end else if (w_commit && r_pending) begin
                r_display <= r_shadow;
                r_pending <= 1'b0;
            end
        end
    end

    assign sel        = r_sel;
    assign hex        = r_display[{r_sel, 2'b00} +: 4];
    assign pending    = r_pending;
    assign frame_tick = r_frame_tick;

`ifdef SEG_LZB_EN
    always_comb begin
        blank = 1'b0;
        case (r_sel)
            2'd3:    blank = (r_display[15:12] == 4'h0);
            2'd2:    blank = (r_display[15:8]  == 8'h00);
            2'd1:    blank = (r_display[15:4]  == 12'h000);
            default: blank = 1'b0;
        endcase
    end
`else
    assign blank = 1'b0;
`endif
endmodule
